perf_cntr_bank: RTL and testbench
=================================

Name: perf_cntr_bank

Overview:
- Parametrised successor to the single 64-bit cycle counter: a bank of NUM_CNTRS event counters behind the dbus perf window (dbus_addr[30]).
- Adds per-counter event inputs, an enable mask, atomic snapshot for coherent hi/lo reads, and sticky overflow flags.
- Counter 0 is wired to constant 1 at top level and serves as mcycle. Other counters take CPU/CFU events such as stall, load, store or CFU op.

Parameters:
NUM_CNTRS, 4, number of counters; 1..28, and 0x20+8*NUM_CNTRS <= 2**ADDR_WIDTH
CNTR_WIDTH, 64, counter width; 33..64, hi word zero-extended above CNTR_WIDTH-32 bits
ADDR_WIDTH, 6, byte-address bits decoded from addr_i

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
addr_i  input  ADDR_WIDTH  byte address; bits [1:0] ignored
wdata_i  input  32  write data
w_en_i  input  1  write strobe, one cycle per write
event_i  input  NUM_CNTRS  per-counter increment request, sampled each cycle
rdata_o  output  32  registered read data
irq_o  output  1  overflow interrupt; constant 0 without PERF_OVF_IRQ_EN

Behaviour:
- Reset is asynchronous, active-low. All of the following clear to 0: counters, shadows, mode, OVF flags, IRQ_MASK, rdata_o, irq_o. EN_MASK resets to all ones.
- Register map (byte offsets); unmapped reads return 0 and unmapped writes are ignored:
  - 0x00 CTRL: wdata[1:0] = global mode. 0 = clear, 1 = run, 2 or 3 = hold. Read returns {30'b0, mode}.
  - 0x04 SNAP: any write copies every counter into its shadow register.
  - 0x08 OVF: read sticky flags [NUM_CNTRS-1:0]; write 1 to clear each bit.
  - 0x0C EN_MASK: bit i gates counter i. R/W, NUM_CNTRS bits.
  - 0x10 IRQ_MASK: R/W only with PERF_OVF_IRQ_EN; otherwise reads 0.
  - 0x20+8*i: shadow i hi word. 0x24+8*i: shadow i lo word.
- Counter update each cycle uses the registered mode, so a CTRL write takes effect on the cycle after the write edge:
  - mode 0: counter <= 0. OVF flags unaffected.
  - mode 1: if event_i[i] && EN_MASK[i], counter <= counter+1.
  - mode 2/3: counter holds.
- Wrap: increment of an all-ones counter yields 0 and sets OVF[i] on the same edge.
- Set/clear collision: OVF set and a W1C clear of the same bit in one cycle leaves the bit set.
- Snapshot: a SNAP write on edge N captures counter values as they stand before edge N's increment. Shadows are visible to reads issued from cycle N+1. Counters themselves are never read directly.
- Read latency: rdata_o <= decode(addr_i) on every edge, 1 cycle, independent of w_en_i. rdata_o therefore reflects register state before any write on the same edge.
- Partial width: with CNTR_WIDTH < 64, the hi word = {zeros, counter[CNTR_WIDTH-1:32]}. Wrap occurs at 2**CNTR_WIDTH.
- event_i is fully synchronous to clk_i; no internal synchroniser.
- Reset mid-count zeroes everything immediately, without waiting for a clock edge.

Optional Feature:
PERF_OVF_IRQ_EN:
- Defined:
  - IRQ_MASK register exists.
  - irq_o is registered: irq_o <= |(OVF & IRQ_MASK), evaluated on the updated flags, so irq_o asserts 1 cycle after the overflow edge.
  - Level-sensitive; deasserts 1 cycle after the W1C write that clears the last masked flag, or after a mask clear.
- Undefined:
  - No IRQ_MASK storage; 0x10 reads 0.
  - irq_o tied to 0.
  - OVF flags still operate.

Test Plan:
- Reset, write CTRL=1, event_i=4'b0001 for 100 cycles, write CTRL=2, write SNAP, read 0x24 and 0x20 -> 100 and 0. Counters 1..3 read 0.
- EN_MASK=4'b1101, event_i=4'b1111 for 10 cycles in run, then SNAP -> counter 1 reads 0; counters 0, 2, 3 read 10.
- Run counter 0 for 5 cycles, SNAP, run 7 more cycles, then read without a new SNAP -> lo reads 5. After a second SNAP -> lo reads 12.
- CNTR_WIDTH=34, counter preloaded to 0x3_FFFF_FFFF via force, one event -> hi=0, lo=0, OVF bit0=1. W1C OVF in the same cycle as a second wrap -> bit stays 1.
- With PERF_OVF_IRQ_EN: IRQ_MASK=1, force a wrap on counter 0 -> irq_o=1 one cycle later. Write OVF=1 -> irq_o=0 one cycle after the write. Without the macro, irq_o stays 0 throughout.
- Deassert rst_ni mid-run with counters at 0x1234 -> all reads return 0, EN_MASK reads 0xF, rdata_o=0 before the next clock edge.

Source files
------------

// File: rtl/perf_cntr_bank.sv
// perf_cntr_bank: bank of NUM_CNTRS event counters behind the dbus perf window.
// Counter 0 is expected to have its event input tied high at the level above,
// so that it serves as mcycle.
//
// Features:
//   - Global run/clear/hold mode.
//   - Per-counter enable mask.
//   - Atomic snapshot into shadow registers, so the hi and lo words read coherently.
//   - Sticky write-1-to-clear overflow flags.
//
// Optional feature macro: PERF_OVF_IRQ_EN
//   Defined:   adds the IRQ_MASK register and a registered, level-sensitive
//              overflow interrupt.
//   Undefined: 0x10 reads 0 and irq_o is tied low.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   addr_i   byte address; bits [1:0] are ignored
//   wdata_i  write data
//   w_en_i   write strobe (one cycle per write)
//   event_i  per-counter increment request, synchronous to clk_i
//   rdata_o  read data for addr_i, registered (1-cycle latency)
//   irq_o    overflow interrupt
//
// Register map (byte offsets):
//   0x00        CTRL      mode[1:0]: 0 = clear, 1 = run, 2/3 = hold
//   0x04        SNAP      any write copies every counter into its shadow
//   0x08        OVF       sticky overflow flags, write 1 to clear
//   0x0C        EN_MASK   per-counter gate
//   0x10        IRQ_MASK  (PERF_OVF_IRQ_EN only)
//   0x20 + 8*i  shadow i, hi word
//   0x24 + 8*i  shadow i, lo word

// One counter and its shadow register.
//   clr   : zero the counter (mode 0)
//   inc   : increment the counter (already gated by run mode and the enable mask)
//   snap  : copy the pre-edge counter value into the shadow
//   shadow: shadow value, zero-extended to 64 bits
//   wrap  : this edge's increment rolls the counter over to 0
module perf_cntr_lane #(
  parameter int CNTR_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr,
  input  logic        inc,
  input  logic        snap,
  output logic [63:0] shadow,
  output logic        wrap
);

  logic [CNTR_WIDTH-1:0] cntr;
  logic [CNTR_WIDTH-1:0] shd;

  assign wrap   = inc & (&cntr);
  assign shadow = 64'(shd);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cntr <= '0;
      shd  <= '0;
    end else begin
      // The shadow captures the value the counter holds before this edge's update.
      if (snap) shd <= cntr;
      if (clr)      cntr <= '0;
      else if (inc) cntr <= cntr + CNTR_WIDTH'(1);
    end
  end

endmodule

module perf_cntr_bank #(
  parameter int NUM_CNTRS  = 4,
  parameter int CNTR_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  w_en_i,
  input  logic [NUM_CNTRS-1:0]  event_i,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);

  // Word indices (byte offset / 4).
  localparam logic [31:0] W_CTRL = 32'd0;
  localparam logic [31:0] W_SNAP = 32'd1;
  localparam logic [31:0] W_OVF  = 32'd2;
  localparam logic [31:0] W_EN   = 32'd3;
  localparam logic [31:0] W_IRQM = 32'd4;
  localparam int          W_SHD0 = 8;

  logic [31:0]                 waddr;
  logic [1:0]                  mode;
  logic [NUM_CNTRS-1:0]        en_mask;
  logic [NUM_CNTRS-1:0]        ovf;
  logic [NUM_CNTRS-1:0]        ovf_clr;
  logic [NUM_CNTRS-1:0]        wrap;
  logic [NUM_CNTRS-1:0]        inc;
  logic [NUM_CNTRS-1:0][63:0]  shadow;
  logic [NUM_CNTRS-1:0]        irq_mask;
  logic                        run;
  logic                        clr;
  logic                        snap;
  logic [31:0]                 rd_nxt;
  logic                        unused;

  assign waddr = 32'(addr_i[ADDR_WIDTH-1:2]);
  // Address low bits and unused write-data bits are ignored by design.
  assign unused = ^{wdata_i, addr_i[1:0]};

  // The counters act on the registered mode, so a CTRL write only takes
  // effect from the following edge.
  assign run  = (mode == 2'd1);
  assign clr  = (mode == 2'd0);
  assign snap = w_en_i && (waddr == W_SNAP);
  assign inc  = {NUM_CNTRS{run}} & event_i & en_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNTRS; gi++) begin : g_lane
      perf_cntr_lane #(.CNTR_WIDTH(CNTR_WIDTH)) u_lane (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (clr),
        .inc    (inc[gi]),
        .snap   (snap),
        .shadow (shadow[gi]),
        .wrap   (wrap[gi])
      );
    end
  endgenerate

  // Write-1-to-clear for the OVF register.
  assign ovf_clr = (w_en_i && (waddr == W_OVF)) ? wdata_i[NUM_CNTRS-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode    <= 2'd0;
      en_mask <= '1;
      ovf     <= '0;
    end else begin
      if (w_en_i && (waddr == W_CTRL)) mode    <= wdata_i[1:0];
      if (w_en_i && (waddr == W_EN))   en_mask <= wdata_i[NUM_CNTRS-1:0];
      // When a flag is set and cleared on the same edge, the set wins.
      ovf <= (ovf & ~ovf_clr) | wrap;
    end
  end

`ifdef PERF_OVF_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_mask <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (w_en_i && (waddr == W_IRQM)) irq_mask <= wdata_i[NUM_CNTRS-1:0];
      // Evaluated on the registered flags, so irq_o rises one cycle after
      // the overflow edge and falls one cycle after the clearing write.
      irq_o <= |(ovf & irq_mask);
    end
  end
`else
  assign irq_mask = '0;
  assign irq_o    = 1'b0;
`endif

  // Read decode. Reads see the pre-edge state, independent of w_en_i.
  always_comb begin
    rd_nxt = '0;
    if (waddr == W_CTRL) rd_nxt = {30'b0, mode};
    if (waddr == W_OVF)  rd_nxt = 32'(ovf);
    if (waddr == W_EN)   rd_nxt = 32'(en_mask);
    if (waddr == W_IRQM) rd_nxt = 32'(irq_mask);
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (waddr == 32'(W_SHD0 + 2*i))     rd_nxt = shadow[i][63:32];
      if (waddr == 32'(W_SHD0 + 2*i + 1)) rd_nxt = shadow[i][31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_o <= '0;
    else         rdata_o <= rd_nxt;
  end

endmodule

// File: tb/tb_perf_cntr_bank.sv
module tb_perf_cntr_bank;
  localparam int NC = 4;
  localparam int CW = 34;
  localparam int AW = 6;
  localparam logic [63:0] MAXV = (64'd1 << CW) - 64'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          w_en = 1'b0;
  logic [NC-1:0] ev = '0;
  logic [31:0]   rdata;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  perf_cntr_bank #(.NUM_CNTRS(NC), .CNTR_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wdata_i(wdata),
    .w_en_i(w_en), .event_i(ev), .rdata_o(rdata), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0]   m_cnt [NC];
  logic [63:0]   m_shd [NC];
  logic [1:0]    m_mode;
  logic [NC-1:0] m_en, m_ovf, m_imask;
  logic [31:0]   m_rdata;
  logic          m_irq;
  // Preload requests from the stimulus thread (mirrors a force on the DUT).
  int            pre_seq = 0;
  int            pre_seen = 0;
  int            pre_idx = 0;
  logic [63:0]   pre_val = '0;

  function automatic logic [31:0] rd_model(input logic [AW-1:0] a);
    int w;
    w = int'(a) & 32'h3C;
    if (w == 'h00) return {30'b0, m_mode};
    if (w == 'h08) return 32'(m_ovf);
    if (w == 'h0C) return 32'(m_en);
`ifdef PERF_OVF_IRQ_EN
    if (w == 'h10) return 32'(m_imask);
`endif
    if (w >= 'h20 && w < 'h20 + 8*NC) begin
      if (w % 8 == 0) return m_shd[(w - 'h20) / 8][63:32];
      else            return m_shd[(w - 'h20) / 8][31:0];
    end
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_shd[i] = 0; end
      m_mode = 0; m_en = '1; m_ovf = 0; m_imask = 0; m_rdata = 0; m_irq = 0;
      pre_seen = pre_seq;
    end else begin
      logic [NC-1:0] wraps;
      logic [NC-1:0] clrb;
      int w;
      if (pre_seen != pre_seq) begin
        m_cnt[pre_idx] = pre_val;
        pre_seen = pre_seq;
      end
      w = int'(addr) & 32'h3C;
      m_rdata = rd_model(addr);
`ifdef PERF_OVF_IRQ_EN
      m_irq = |(m_ovf & m_imask);
`else
      m_irq = 1'b0;
`endif
      if (w_en && w == 'h04)
        for (int i = 0; i < NC; i++) m_shd[i] = m_cnt[i];
      wraps = '0;
      for (int i = 0; i < NC; i++) begin
        if (m_mode == 0) m_cnt[i] = 0;
        else if (m_mode == 1 && ev[i] && m_en[i]) begin
          if (m_cnt[i] == MAXV) begin m_cnt[i] = 0; wraps[i] = 1'b1; end
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      clrb = (w_en && w == 'h08) ? wdata[NC-1:0] : '0;
      m_ovf = (m_ovf & ~clrb) | wraps;
      if (w_en && w == 'h00) m_mode = wdata[1:0];
      if (w_en && w == 'h0C) m_en = wdata[NC-1:0];
`ifdef PERF_OVF_IRQ_EN
      if (w_en && w == 'h10) m_imask = wdata[NC-1:0];
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata_vs_model", rdata, m_rdata);
      check("irq_vs_model", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [AW-1:0] a, input logic [31:0] d, input logic we,
                     input logic [NC-1:0] e);
    addr = a; wdata = d; w_en = we; ev = e;
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    cyc(a, d, 1'b1, '0);
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    cyc(a, 32'h0, 1'b0, '0);
    check(name, rdata, exp);
  endtask

  task automatic run_ev(input int n, input logic [NC-1:0] e);
    for (int k = 0; k < n; k++) cyc(6'h00, 32'h0, 1'b0, e);
  endtask

  // Called at a negedge: forces a counter value that the next edge sees.
  task automatic preload(input int idx, input logic [63:0] v);
    case (idx)
      0: force dut.g_lane[0].u_lane.cntr = v[CW-1:0];
      default: force dut.g_lane[1].u_lane.cntr = v[CW-1:0];
    endcase
    pre_idx = idx; pre_val = v; pre_seq++;
    #1;
    case (idx)
      0: release dut.g_lane[0].u_lane.cntr;
      default: release dut.g_lane[1].u_lane.cntr;
    endcase
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Reset state
    rd_chk("rst_en_mask", 6'h0C, 32'hF);
    rd_chk("rst_ctrl", 6'h00, 32'h0);

    // Counter 0 counts 100 events
    wr(6'h00, 32'd1);
    run_ev(100, 4'b0001);
    wr(6'h00, 32'd2);
    wr(6'h04, 32'h0);
    rd_chk("c0_lo_100", 6'h24, 32'd100);
    rd_chk("c0_hi_0", 6'h20, 32'd0);
    rd_chk("c1_lo_0", 6'h2C, 32'd0);
    rd_chk("c3_lo_0", 6'h3C, 32'd0);

    // Enable mask gates counter 1
    wr(6'h00, 32'd0);
    wr(6'h0C, 32'hD);
    wr(6'h00, 32'd1);
    run_ev(10, 4'b1111);
    wr(6'h00, 32'd2);
    wr(6'h04, 32'h0);
    rd_chk("mask_c0", 6'h24, 32'd10);
    rd_chk("mask_c1", 6'h2C, 32'd0);
    rd_chk("mask_c2", 6'h34, 32'd10);
    rd_chk("mask_c3", 6'h3C, 32'd10);

    // Snapshot coherence
    wr(6'h00, 32'd0);
    wr(6'h0C, 32'hF);
    wr(6'h00, 32'd1);
    run_ev(5, 4'b0001);
    wr(6'h04, 32'h0);
    run_ev(7, 4'b0001);
    rd_chk("snap_old_5", 6'h24, 32'd5);
    wr(6'h04, 32'h0);
    rd_chk("snap_new_12", 6'h24, 32'd12);

    // Wrap at 2**34 and sticky overflow
`ifdef PERF_OVF_IRQ_EN
    wr(6'h10, 32'h1);
    rd_chk("irq_mask_rd", 6'h10, 32'h1);
`else
    rd_chk("irq_mask_absent", 6'h10, 32'h0);
`endif
    preload(0, MAXV);
    cyc(6'h00, 32'h0, 1'b0, 4'b0001);
    wr(6'h04, 32'h0);
`ifdef PERF_OVF_IRQ_EN
    check("irq_after_wrap", {31'b0, irq}, 32'd1);
`else
    check("irq_tied_low", {31'b0, irq}, 32'd0);
`endif
    rd_chk("wrap_hi", 6'h20, 32'd0);
    rd_chk("wrap_lo", 6'h24, 32'd0);
    rd_chk("ovf_set", 6'h08, 32'h1);
    preload(0, MAXV);
    cyc(6'h08, 32'h1, 1'b1, 4'b0001);
    rd_chk("ovf_collision", 6'h08, 32'h1);
    wr(6'h08, 32'h1);
    rd_chk("ovf_cleared", 6'h08, 32'h0);
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // Partial-width hi word
    preload(1, 64'h2_1234_5678);
    cyc(6'h00, 32'h0, 1'b0, 4'b0000);
    wr(6'h04, 32'h0);
    rd_chk("hi_partial", 6'h28, 32'h2);
    rd_chk("lo_partial", 6'h2C, 32'h1234_5678);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [AW-1:0] a;
      logic [31:0]   d;
      logic          we;
      a = AW'($urandom_range(0, 63));
      d = $urandom;
      we = ($urandom_range(0, 3) == 0);
      if (we && a[5:2] == 4'h0) d = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'd1;
      if (we && a[5:2] == 4'h3 && $urandom_range(0, 1) == 0) d = 32'hF;
      cyc(a, d, we, NC'($urandom));
    end

    // Asynchronous reset mid-run
    wr(6'h00, 32'd1);
    preload(1, 64'h1234);
    cyc(6'h00, 32'h0, 1'b0, 4'b0000);
    wr(6'h04, 32'h0);
    rd_chk("pre_rst_c1", 6'h34 - 6'h8, 32'h1234);
    cyc(6'h2C, 32'h0, 1'b0, 4'b0000);
    #2 rst_n = 1'b0;
    #1 check("async_rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_en", 6'h0C, 32'hF);
    rd_chk("post_rst_c1", 6'h2C, 32'h0);
    rd_chk("post_rst_ovf", 6'h08, 32'h0);
    rd_chk("post_rst_ctrl", 6'h00, 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
